// File: rtl/mem_access.sv
// mem_access: memory-access stage engine between the Ex/Mem register and the
// data memory port. It turns a load/store micro-op into one valid/grant
// transaction, stalls the pipeline while that transaction is outstanding, and
// returns load data formatted (shifted and sign/zero extended) for write-back.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses issue no memory request and complete
//               one cycle later with Mem_Misalign set.
//   undefined - misaligned addresses are force-aligned and the access
//               proceeds normally; Mem_Misalign stays 0.

module mem_access #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ExMem_MemRd,
  input  logic                  ExMem_MemWrt,
  input  logic [2:0]            ExMem_Funct3,
  input  logic [DATA_WIDTH-1:0] ExMem_Addr,
  input  logic [DATA_WIDTH-1:0] ExMem_DataWrt,
  output logic                  Mem_Stall,
  output logic                  Mem_Valid,
  output logic [DATA_WIDTH-1:0] Mem_DataRd,
  output logic                  Mem_Misalign,
  output logic                  DMem_Req,
  input  logic                  DMem_Gnt,
  output logic                  DMem_Wen,
  output logic [DATA_WIDTH-1:0] DMem_Addr,
  output logic [3:0]            DMem_BE,
  output logic [DATA_WIDTH-1:0] DMem_WData,
  input  logic                  DMem_RValid,
  input  logic [DATA_WIDTH-1:0] DMem_RData
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t                  state;
  logic                    load_q;
  logic [2:0]              funct3_q;
  logic [1:0]              offset_q;

  logic                    access_req;
  logic                    size_half;
  logic                    size_word;
  logic                    trap;
  logic [DATA_WIDTH-1:0]   aligned_addr;
  logic [3:0]              lane_be;
  logic [DATA_WIDTH-1:0]   lane_wdata;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   load_data;

  // Decode the incoming micro-op: size, effective (possibly aligned) address,
  // misalignment trap and the lane-steered byte enables and store data.
  always_comb begin
    access_req   = ExMem_MemRd | ExMem_MemWrt;
    size_half    = (ExMem_Funct3[1:0] == 2'b01);
    size_word    = ExMem_Funct3[1];
    aligned_addr = ExMem_Addr;
    trap         = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (size_half & ExMem_Addr[0]) | (size_word & (|ExMem_Addr[1:0]));
`else
    if (size_half) begin
      aligned_addr[0] = 1'b0;
    end else if (size_word) begin
      aligned_addr[1:0] = 2'b00;
    end
`endif
    if (size_word) begin
      lane_be    = 4'b1111;
      lane_wdata = ExMem_DataWrt;
    end else if (size_half) begin
      lane_be    = aligned_addr[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {(DATA_WIDTH/16){ExMem_DataWrt[15:0]}};
    end else begin
      lane_be    = 4'b0001 << aligned_addr[1:0];
      lane_wdata = {(DATA_WIDTH/8){ExMem_DataWrt[7:0]}};
    end
  end

  // Right-align the returned word to the access offset and extend it.
  always_comb begin
    shifted = DMem_RData >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Stall while a new op is arriving or a transaction is outstanding;
  // forced low while reset is held so the pipeline is never frozen by it.
  always_comb begin
    Mem_Stall = rst_n & (((state == IDLE) & access_req) |
                         (state == REQ) | (state == WAIT));
  end

  // Transaction FSM with registered memory-port and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      load_q       <= 1'b0;
      funct3_q     <= 3'b000;
      offset_q     <= 2'b00;
      Mem_Valid    <= 1'b0;
      Mem_Misalign <= 1'b0;
      Mem_DataRd   <= '0;
      DMem_Req     <= 1'b0;
      DMem_Wen     <= 1'b0;
      DMem_Addr    <= '0;
      DMem_BE      <= 4'b0000;
      DMem_WData   <= '0;
    end else begin
      Mem_Valid    <= 1'b0;
      Mem_Misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (access_req) begin
            load_q   <= ExMem_MemRd;
            funct3_q <= ExMem_Funct3;
            offset_q <= aligned_addr[1:0];
            if (trap) begin
              Mem_Valid    <= 1'b1;
              Mem_Misalign <= 1'b1;
              state        <= DONE;
            end else begin
              DMem_Req   <= 1'b1;
              DMem_Wen   <= ~ExMem_MemRd;
              DMem_Addr  <= {aligned_addr[DATA_WIDTH-1:2], 2'b00};
              DMem_BE    <= lane_be;
              DMem_WData <= lane_wdata;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (DMem_Gnt) begin
            DMem_Req <= 1'b0;
            if (load_q) begin
              state <= WAIT;
            end else begin
              Mem_Valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        WAIT: begin
          if (DMem_RValid) begin
            Mem_DataRd <= load_data;
            Mem_Valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed testbench for mem_access. Stimulus pushes the
// expected completion (data, misalign flag, cycle) into a scoreboard queue;
// a monitor pops and compares whenever Mem_Valid is seen.

module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ExMem_MemRd;
  logic        ExMem_MemWrt;
  logic [2:0]  ExMem_Funct3;
  logic [31:0] ExMem_Addr;
  logic [31:0] ExMem_DataWrt;
  logic        Mem_Stall;
  logic        Mem_Valid;
  logic [31:0] Mem_DataRd;
  logic        Mem_Misalign;
  logic        DMem_Req;
  logic        DMem_Gnt;
  logic        DMem_Wen;
  logic [31:0] DMem_Addr;
  logic [3:0]  DMem_BE;
  logic [31:0] DMem_WData;
  logic        DMem_RValid;
  logic [31:0] DMem_RData;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        misalign;
    int          cycle;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] model_rd = 32'h0;

  mem_access #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ExMem_MemRd  (ExMem_MemRd),
    .ExMem_MemWrt (ExMem_MemWrt),
    .ExMem_Funct3 (ExMem_Funct3),
    .ExMem_Addr   (ExMem_Addr),
    .ExMem_DataWrt(ExMem_DataWrt),
    .Mem_Stall    (Mem_Stall),
    .Mem_Valid    (Mem_Valid),
    .Mem_DataRd   (Mem_DataRd),
    .Mem_Misalign (Mem_Misalign),
    .DMem_Req     (DMem_Req),
    .DMem_Gnt     (DMem_Gnt),
    .DMem_Wen     (DMem_Wen),
    .DMem_Addr    (DMem_Addr),
    .DMem_BE      (DMem_BE),
    .DMem_WData   (DMem_WData),
    .DMem_RValid  (DMem_RValid),
    .DMem_RData   (DMem_RData)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected completions.
  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (Mem_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: got Mem_Valid=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_data"}, Mem_DataRd, e.data);
        checkOutput({e.name, "_misalign"}, {31'b0, Mem_Misalign}, {31'b0, e.misalign});
        checkOutput({e.name, "_cycle"}, cyc, e.cycle);
      end
    end
  end

  // One complete access: drive the op, play the memory side with the given
  // grant/response delays, check the port each cycle, queue the completion.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic mis,
                               input int gnt_dly, input int rv_dly, input logic spurious,
                               input logic [31:0] rdata, input logic [31:0] exp_addr,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic [31:0] exp_rd);
    exp_t e;
    logic trap;
    int   c0;
    trap = TRAP & mis;
    @(posedge clk); #1;
    ExMem_MemRd   = rd;
    ExMem_MemWrt  = wr;
    ExMem_Funct3  = f3;
    ExMem_Addr    = addr;
    ExMem_DataWrt = wdata;
    c0 = cyc;
    if (rd && !trap) model_rd = exp_rd;
    e.name     = name;
    e.data     = model_rd;
    e.misalign = trap;
    e.cycle    = trap ? c0 + 1 : (rd ? c0 + 3 + gnt_dly + rv_dly : c0 + 2 + gnt_dly);
    sb.push_back(e);
    @(negedge clk);
    checkOutput({name, "_stall_c0"}, {31'b0, Mem_Stall}, 32'd1);
    if (trap) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({name, "_no_req"}, {31'b0, DMem_Req}, 32'd0);
      checkOutput({name, "_stall_done"}, {31'b0, Mem_Stall}, 32'd0);
    end else begin
      @(posedge clk); #1;
      for (int i = 0; i <= gnt_dly; i++) begin
        DMem_Gnt    = (i == gnt_dly);
        DMem_RValid = spurious;
        DMem_RData  = 32'hBADBAD00;
        @(negedge clk);
        checkOutput({name, "_req"}, {31'b0, DMem_Req}, 32'd1);
        checkOutput({name, "_addr"}, DMem_Addr, exp_addr);
        checkOutput({name, "_be"}, {28'b0, DMem_BE}, {28'b0, exp_be});
        checkOutput({name, "_wen"}, {31'b0, DMem_Wen}, {31'b0, wr & ~rd});
        checkOutput({name, "_stall_req"}, {31'b0, Mem_Stall}, 32'd1);
        if (!rd) checkOutput({name, "_wdata"}, DMem_WData, exp_wdata);
        @(posedge clk); #1;
      end
      DMem_Gnt    = 1'b0;
      DMem_RValid = 1'b0;
      if (rd) begin
        for (int j = 0; j <= rv_dly; j++) begin
          DMem_RValid = (j == rv_dly);
          DMem_RData  = (j == rv_dly) ? rdata : 32'hBADBAD00;
          @(negedge clk);
          checkOutput({name, "_req_wait"}, {31'b0, DMem_Req}, 32'd0);
          checkOutput({name, "_stall_wait"}, {31'b0, Mem_Stall}, 32'd1);
          @(posedge clk); #1;
        end
      end
      DMem_RValid = 1'b0;
      @(negedge clk);
      checkOutput({name, "_stall_done"}, {31'b0, Mem_Stall}, 32'd0);
    end
    @(posedge clk); #1;
    ExMem_MemRd  = 1'b0;
    ExMem_MemWrt = 1'b0;
  endtask

  // Load that is reset while waiting for its response; the late response
  // arrives in IDLE and must be ignored.
  task automatic resetDuringWait();
    @(posedge clk); #1;
    ExMem_MemRd  = 1'b1;
    ExMem_Funct3 = 3'b010;
    ExMem_Addr   = 32'h0000_0100;
    @(negedge clk);
    checkOutput("rst_stall_c0", {31'b0, Mem_Stall}, 32'd1);
    @(posedge clk); #1;
    DMem_Gnt = 1'b1;
    @(negedge clk);
    checkOutput("rst_req", {31'b0, DMem_Req}, 32'd1);
    @(posedge clk); #1;
    DMem_Gnt = 1'b0;
    @(negedge clk);
    checkOutput("rst_stall_wait", {31'b0, Mem_Stall}, 32'd1);
    @(posedge clk); #1;
    rst_n       = 1'b0;
    ExMem_MemRd = 1'b0;
    @(negedge clk);
    checkOutput("rst_stall_in_reset", {31'b0, Mem_Stall}, 32'd0);
    @(posedge clk); #1;
    rst_n       = 1'b1;
    DMem_RValid = 1'b1;
    DMem_RData  = 32'h5555_5555;
    @(negedge clk);
    checkOutput("rst_req_dropped", {31'b0, DMem_Req}, 32'd0);
    checkOutput("rst_datard", Mem_DataRd, 32'h0);
    checkOutput("rst_valid", {31'b0, Mem_Valid}, 32'd0);
    checkOutput("rst_stall_idle", {31'b0, Mem_Stall}, 32'd0);
    @(posedge clk); #1;
    DMem_RValid = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid_late", {31'b0, Mem_Valid}, 32'd0);
    checkOutput("rst_datard_late", Mem_DataRd, 32'h0);
    checkOutput("rst_stall_late", {31'b0, Mem_Stall}, 32'd0);
    model_rd = 32'h0;
  endtask

  // Directed test sequence.
  initial begin
    rst_n         = 1'b0;
    ExMem_MemRd   = 1'b0;
    ExMem_MemWrt  = 1'b0;
    ExMem_Funct3  = 3'b000;
    ExMem_Addr    = 32'h0;
    ExMem_DataWrt = 32'h0;
    DMem_Gnt      = 1'b0;
    DMem_RValid   = 1'b0;
    DMem_RData    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", {31'b0, Mem_Valid}, 32'd0);
    checkOutput("reset_datard", Mem_DataRd, 32'h0);
    checkOutput("reset_misalign", {31'b0, Mem_Misalign}, 32'd0);
    checkOutput("reset_req", {31'b0, DMem_Req}, 32'd0);
    checkOutput("reset_wen", {31'b0, DMem_Wen}, 32'd0);
    checkOutput("reset_addr", DMem_Addr, 32'h0);
    checkOutput("reset_be", {28'b0, DMem_BE}, 32'd0);
    checkOutput("reset_wdata", DMem_WData, 32'h0);
    checkOutput("reset_stall", {31'b0, Mem_Stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_stall", {31'b0, Mem_Stall}, 32'd0);

    //             name   rd    wr    f3      addr          wdata         mis  g  r  sp    rdata         exp_addr      be       exp_wdata     exp_rd
    applyStimulus("lw",   1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,       1'b0, 0, 0, 1'b0, 32'hDEADBEEF, 32'h0000_0100, 4'b1111, 32'h0,       32'hDEADBEEF);
    applyStimulus("lb",   1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,       1'b0, 0, 0, 1'b0, 32'h80FF7F01, 32'h0000_0100, 4'b1000, 32'h0,       32'hFFFFFF80);
    applyStimulus("lbu",  1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,       1'b0, 0, 0, 1'b0, 32'h80FF7F01, 32'h0000_0100, 4'b1000, 32'h0,       32'h00000080);
    applyStimulus("lh",   1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,       1'b0, 0, 0, 1'b0, 32'h80FF7F01, 32'h0000_0100, 4'b1100, 32'h0,       32'hFFFF80FF);
    applyStimulus("lhu",  1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,       1'b0, 0, 0, 1'b0, 32'h80FF7F01, 32'h0000_0100, 4'b0011, 32'h0,       32'h00007F01);
    applyStimulus("sb",   1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h000000AB, 1'b0, 0, 0, 1'b0, 32'h0,       32'h0000_0000, 4'b0010, 32'hABABABAB, 32'h0);
    applyStimulus("sw_gnt3", 1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h12345678, 1'b0, 3, 0, 1'b0, 32'h0,    32'h0000_0204, 4'b1111, 32'h12345678, 32'h0);
    applyStimulus("sh",   1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h0000BEEF, 1'b0, 0, 0, 1'b0, 32'h0,       32'h0000_0004, 4'b1100, 32'hBEEFBEEF, 32'h0);
    applyStimulus("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,     1'b1, 1, 2, 1'b0, 32'hCAFEF00D, 32'h0000_0100, 4'b1111, 32'h0,       32'hCAFEF00D);
    applyStimulus("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'h0,     1'b1, 0, 0, 1'b0, 32'h12348765, 32'h0000_0000, 4'b0011, 32'h0,       32'hFFFF8765);
    applyStimulus("rd_wr_both", 1'b1, 1'b1, 3'b100, 32'h0000_0201, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, 32'h00005A00, 32'h0000_0200, 4'b0010, 32'h0, 32'h0000005A);
    applyStimulus("lw_spurious", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1'b0, 1, 1, 1'b1, 32'h01020304, 32'h0000_0300, 4'b1111, 32'h0,   32'h01020304);

    resetDuringWait();

    applyStimulus("lhu_after_rst", 1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 1'b0, 0, 0, 1'b0, 32'hABCD0000, 32'h0000_0200, 4'b1100, 32'h0, 32'h0000ABCD);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got time limit reached, expected sequence to complete");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
